// File: rtl/regfile_pkg.sv
// Shared defaults and the write-port bundle for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = $clog2(DEF_NREG);

    // One write port at the default geometry.
    typedef struct packed {
        logic                en;
        logic [DEF_AW-1:0]   addr;
        logic [DEF_XLEN-1:0] data;
    } wr_port_t;

endpackage

// File: rtl/scoreboard_regfile_rdport.sv
// One combinational read port: x0 zeroing, write-through bypass (wr1 over wr0), operand ready.
module scoreboard_regfile_rdport #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] arr_data_i,
    input  logic            busy_i,
    input  logic            wr0_en_i,
    input  logic [AW-1:0]   wr0_addr_i,
    input  logic [XLEN-1:0] wr0_data_i,
    input  logic            wr1_en_i,
    input  logic [AW-1:0]   wr1_addr_i,
    input  logic [XLEN-1:0] wr1_data_i,
    output logic [XLEN-1:0] data_o,
    output logic            ready_o
);

    // Write enables arrive already qualified by reset and nonzero address.
    always_comb begin
        data_o  = arr_data_i;
        ready_o = !busy_i;
        if (addr_i == '0) begin
            data_o  = '0;
            ready_o = 1'b1;
        end else if (wr1_en_i && (wr1_addr_i == addr_i)) begin
            data_o  = wr1_data_i;
            ready_o = 1'b1;
        end else if (wr0_en_i && (wr0_addr_i == addr_i)) begin
            data_o  = wr0_data_i;
            ready_o = 1'b1;
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Two-read / two-write register file with a per-register busy scoreboard and sticky double-issue error.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clock_i,
    input  logic            rst_n_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            rs1_ready_o,
    output logic            rs2_ready_o,
    input  logic            wr0_en_i,
    input  logic [AW-1:0]   wr0_addr_i,
    input  logic [XLEN-1:0] wr0_data_i,
    input  logic            wr1_en_i,
    input  logic [AW-1:0]   wr1_addr_i,
    input  logic [XLEN-1:0] wr1_data_i,
    input  logic            issue_i,
    input  logic [AW-1:0]   issue_addr_i,
    output logic [NREG-1:0] busy_o,
    output logic            err_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            err_q, err_d;

    logic wr0_eff, wr1_eff, issue_eff, issue_written;

    // Anything presented during a reset cycle, or aimed at x0, is discarded.
    assign wr0_eff   = wr0_en_i && rst_n_i && (wr0_addr_i != '0);
    assign wr1_eff   = wr1_en_i && rst_n_i && (wr1_addr_i != '0);
    assign issue_eff = issue_i  && rst_n_i && (issue_addr_i != '0);
    assign issue_written = (wr0_eff && (wr0_addr_i == issue_addr_i)) ||
                           (wr1_eff && (wr1_addr_i == issue_addr_i));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        err_d  = err_q;
        if (wr0_eff) begin
            regs_d[wr0_addr_i] = wr0_data_i;
            busy_d[wr0_addr_i] = 1'b0;
        end
        // wr1 applied last so it wins a same-address collision.
        if (wr1_eff) begin
            regs_d[wr1_addr_i] = wr1_data_i;
            busy_d[wr1_addr_i] = 1'b0;
        end
        // A new producer overrides the clear from a completing write.
        if (issue_eff) begin
            if (busy_q[issue_addr_i] && !issue_written) begin
                err_d = 1'b1;
            end
            busy_d[issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = '0;
            end
            busy_d = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
        err_q  <= err_d;
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

    scoreboard_regfile_rdport #(.XLEN(XLEN), .AW(AW)) u_rd1 (
        .addr_i     (rs1_addr_i),
        .arr_data_i (regs_q[rs1_addr_i]),
        .busy_i     (busy_q[rs1_addr_i]),
        .wr0_en_i   (wr0_eff),
        .wr0_addr_i (wr0_addr_i),
        .wr0_data_i (wr0_data_i),
        .wr1_en_i   (wr1_eff),
        .wr1_addr_i (wr1_addr_i),
        .wr1_data_i (wr1_data_i),
        .data_o     (rs1_data_o),
        .ready_o    (rs1_ready_o)
    );

    scoreboard_regfile_rdport #(.XLEN(XLEN), .AW(AW)) u_rd2 (
        .addr_i     (rs2_addr_i),
        .arr_data_i (regs_q[rs2_addr_i]),
        .busy_i     (busy_q[rs2_addr_i]),
        .wr0_en_i   (wr0_eff),
        .wr0_addr_i (wr0_addr_i),
        .wr0_data_i (wr0_data_i),
        .wr1_en_i   (wr1_eff),
        .wr1_addr_i (wr1_addr_i),
        .wr1_data_i (wr1_data_i),
        .data_o     (rs2_data_o),
        .ready_o    (rs2_ready_o)
    );

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: hand-computed expectations checked with immediate assertions.
module tb_scoreboard_regfile;
    import regfile_pkg::*;

    logic              clock_i = 1'b0;
    logic              rst_n_i;
    logic [DEF_AW-1:0] rs1_addr_i, rs2_addr_i;
    logic [31:0]       rs1_data_o, rs2_data_o;
    logic              rs1_ready_o, rs2_ready_o;
    wr_port_t          w0, w1;
    logic              issue_i;
    logic [DEF_AW-1:0] issue_addr_i;
    logic [31:0]       busy_o;
    logic              err_o;

    int total = 0;
    int bad   = 0;

    always #5 clock_i = ~clock_i;

    scoreboard_regfile dut (
        .clock_i      (clock_i),
        .rst_n_i      (rst_n_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_data_o   (rs1_data_o),
        .rs2_data_o   (rs2_data_o),
        .rs1_ready_o  (rs1_ready_o),
        .rs2_ready_o  (rs2_ready_o),
        .wr0_en_i     (w0.en),
        .wr0_addr_i   (w0.addr),
        .wr0_data_i   (w0.data),
        .wr1_en_i     (w1.en),
        .wr1_addr_i   (w1.addr),
        .wr1_data_i   (w1.data),
        .issue_i      (issue_i),
        .issue_addr_i (issue_addr_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        w0 = '0;
        w1 = '0;
        issue_i = 1'b0;
        issue_addr_i = '0;
    endtask

    // Advance one edge; inputs change 1 time unit later, away from the edge.
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        rs1_addr_i = '0;
        rs2_addr_i = '0;
        idle();
        tick();
        tick();
        rst_n_i = 1'b1;
        #1;

        // Reset state across every address
        for (int a = 0; a < 32; a++) begin
            rs1_addr_i = DEF_AW'(a);
            rs2_addr_i = DEF_AW'(31 - a);
            #1;
            chk($sformatf("rst_rs1_data[%0d]", a), 64'(rs1_data_o), 64'h0);
            chk($sformatf("rst_rs1_rdy[%0d]", a), 64'(rs1_ready_o), 64'h1);
            chk($sformatf("rst_rs2_data[%0d]", 31 - a), 64'(rs2_data_o), 64'h0);
            chk($sformatf("rst_rs2_rdy[%0d]", 31 - a), 64'(rs2_ready_o), 64'h1);
        end
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);

        // Issue x5, then resolve it through wr0 with same-cycle bypass
        issue_i = 1'b1; issue_addr_i = 5'd5;
        tick();
        idle();
        rs1_addr_i = 5'd5;
        #1;
        chk("x5_busy", 64'(busy_o), 64'h20);
        chk("x5_rdy_pending", 64'(rs1_ready_o), 64'h0);
        w0 = '{en: 1'b1, addr: 5'd5, data: 32'hDEADBEEF};
        #1;
        chk("x5_bypass_data", 64'(rs1_data_o), 64'hDEADBEEF);
        chk("x5_bypass_rdy", 64'(rs1_ready_o), 64'h1);
        tick();
        idle();
        #1;
        chk("x5_busy_clear", 64'(busy_o), 64'h0);
        chk("x5_stored", 64'(rs1_data_o), 64'hDEADBEEF);
        chk("x5_rdy_after", 64'(rs1_ready_o), 64'h1);

        // Same-address collision: wr1 wins
        w0 = '{en: 1'b1, addr: 5'd7, data: 32'h1111};
        w1 = '{en: 1'b1, addr: 5'd7, data: 32'h2222};
        rs2_addr_i = 5'd7;
        #1;
        chk("x7_bypass_wr1", 64'(rs2_data_o), 64'h2222);
        tick();
        idle();
        #1;
        chk("x7_stored_wr1", 64'(rs2_data_o), 64'h2222);

        // Independent writes to non-busy registers, bypass on each read port
        w0 = '{en: 1'b1, addr: 5'd8, data: 32'hAAAA5555};
        w1 = '{en: 1'b1, addr: 5'd9, data: 32'hBBBB0000};
        rs1_addr_i = 5'd8;
        rs2_addr_i = 5'd9;
        #1;
        chk("x8_bypass_wr0", 64'(rs1_data_o), 64'hAAAA5555);
        chk("x9_bypass_wr1", 64'(rs2_data_o), 64'hBBBB0000);
        tick();
        idle();
        #1;
        chk("x8_stored", 64'(rs1_data_o), 64'hAAAA5555);
        chk("x9_stored", 64'(rs2_data_o), 64'hBBBB0000);
        chk("legal_write_busy", 64'(busy_o), 64'h0);

        // x0 ignores writes and issues
        w0 = '{en: 1'b1, addr: 5'd0, data: 32'hFFFFFFFF};
        issue_i = 1'b1; issue_addr_i = 5'd0;
        rs1_addr_i = 5'd0;
        #1;
        chk("x0_bypass_zero", 64'(rs1_data_o), 64'h0);
        chk("x0_rdy", 64'(rs1_ready_o), 64'h1);
        tick();
        idle();
        #1;
        chk("x0_data", 64'(rs1_data_o), 64'h0);
        chk("x0_busy", 64'(busy_o), 64'h0);
        chk("x0_err", 64'(err_o), 64'h0);

        // Double issue to x3 raises a sticky error
        issue_i = 1'b1; issue_addr_i = 5'd3;
        tick();
        chk("x3_first_no_err", 64'(err_o), 64'h0);
        tick();
        idle();
        #1;
        chk("x3_err_set", 64'(err_o), 64'h1);
        chk("x3_busy", 64'(busy_o), 64'h8);
        tick();
        chk("x3_err_sticky", 64'(err_o), 64'h1);

        // Issue and write x4 together: busy stays set, data stored
        issue_i = 1'b1; issue_addr_i = 5'd4;
        w1 = '{en: 1'b1, addr: 5'd4, data: 32'h44};
        tick();
        idle();
        rs1_addr_i = 5'd4;
        #1;
        chk("x4_busy", 64'(busy_o), 64'h18);
        chk("x4_data", 64'(rs1_data_o), 64'h44);
        chk("x4_rdy", 64'(rs1_ready_o), 64'h0);

        // Issue x9, then a one-cycle reset with a pending write and issue
        issue_i = 1'b1; issue_addr_i = 5'd9;
        tick();
        idle();
        #1;
        chk("pre_rst_busy", 64'(busy_o), 64'h218);
        rst_n_i = 1'b0;
        w0 = '{en: 1'b1, addr: 5'd9, data: 32'h99};
        issue_i = 1'b1; issue_addr_i = 5'd10;
        rs1_addr_i = 5'd7;
        rs2_addr_i = 5'd9;
        #1;
        chk("in_rst_read_array", 64'(rs1_data_o), 64'h2222);
        chk("in_rst_no_bypass", 64'(rs2_data_o), 64'hBBBB0000);
        tick();
        rst_n_i = 1'b1;
        idle();
        #1;
        chk("post_rst_busy", 64'(busy_o), 64'h0);
        chk("post_rst_err", 64'(err_o), 64'h0);
        chk("post_rst_x9", 64'(rs2_data_o), 64'h0);
        chk("post_rst_x9_rdy", 64'(rs2_ready_o), 64'h1);
        chk("post_rst_x7", 64'(rs1_data_o), 64'h0);
        tick();
        chk("post_rst_busy_hold", 64'(busy_o), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the register count; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter AW, default $clog2(NREG), meaning the address width.
REQ-004 The block SHALL have port clock_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have ports rs1_addr_i and rs2_addr_i, input, AW bits each: read addresses.
REQ-007 The block SHALL have ports rs1_data_o and rs2_data_o, output, XLEN bits each: read data.
REQ-008 The block SHALL have ports rs1_ready_o and rs2_ready_o, output, 1 bit each: the operand is valid this cycle.
REQ-009 The block SHALL have write port 0 as wr0_en_i (1 bit), wr0_addr_i (AW bits) and wr0_data_i (XLEN bits), all inputs.
REQ-010 The block SHALL have write port 1 as wr1_en_i (1 bit), wr1_addr_i (AW bits) and wr1_data_i (XLEN bits), all inputs.
REQ-011 The block SHALL have ports issue_i (input, 1 bit) and issue_addr_i (input, AW bits): the destination register is marked pending.
REQ-012 The block SHALL have port busy_o, output, NREG bits: the scoreboard vector, with bit 0 constant 0.
REQ-013 The block SHALL have port err_o, output, 1 bit: a sticky flag for a double issue to a pending register.

Function
REQ-014 Register 0 SHALL read as 0, ignore writes, never become busy and always report ready.
REQ-015 Reads SHALL be combinational, with zero latency from the address to the data.
REQ-016 A read whose address matches an enabled write in the same cycle SHALL return the write data (write-through bypass).
REQ-017 When wr0 and wr1 target the same nonzero address in the same cycle, wr1 SHALL win for both the array and the bypass.
REQ-018 An enabled write SHALL update the array at the next rising edge and clear the busy bit of its address.
REQ-019 issue_i with a nonzero issue_addr_i SHALL set busy[issue_addr_i] at the next rising edge.
REQ-020 Issue and write to the same address in the same cycle SHALL leave busy set, because the new producer dominates.
REQ-021 rsN_ready_o SHALL be 1 when busy[rsN_addr_i] is 0 or a same-cycle write to that address is bypassing; otherwise it SHALL be 0.
REQ-022 Issue to an address whose busy bit is 1 and which is not being written this cycle SHALL set err_o at the next edge and still keep the bit set.
REQ-023 err_o SHALL clear only on reset.
REQ-024 Issue to register 0 SHALL be a no-op and SHALL NOT raise err_o.
REQ-025 A write to a register that is not busy SHALL be legal: the data is stored and busy stays 0.

Reset
REQ-026 While rst_n_i is 0 at a rising edge, all registers, busy_o and err_o SHALL become 0.
REQ-027 Writes and issues presented in a reset cycle SHALL be discarded.
REQ-028 Read ports SHALL remain combinational during reset, returning array contents; after the reset edge every read returns 0 with ready 1.

Structure
REQ-029 Package regfile_pkg SHALL hold the default XLEN and NREG and a write-port struct type (en, addr, data).
REQ-030 Sub-module scoreboard_regfile_rdport SHALL implement one read port (x0 zeroing, two-port bypass priority, ready) and be instantiated twice.

Verification
REQ-031 Reset, then read all addresses -> data 0, ready 1, busy_o 0, err_o 0.
REQ-032 Issue x5; next cycle read x5 -> ready 0; then write x5=0xDEADBEEF on wr0 -> same-cycle rs1_data_o 0xDEADBEEF with ready 1; next cycle busy[5]=0.
REQ-033 wr0 x7=0x1111 and wr1 x7=0x2222 in the same cycle -> bypass 0x2222; next cycle read gives 0x2222.
REQ-034 Write x0=0xFFFFFFFF plus issue x0 -> read x0 gives 0, busy_o[0]=0, err_o=0.
REQ-035 Issue x3 twice in consecutive cycles -> err_o=1 persists; issue x4 plus wr1 x4 in the same cycle -> busy[4]=1.
REQ-036 Deassert rst_n_i for one cycle mid-stream with x9 busy and a pending write -> busy_o=0, x9 reads 0, err_o=0.
